// File: rtl/ltc2656_pkg.sv
// Shared codes, LTC2656 command nibbles and sequencer state encoding.
package ltc2656_pkg;

  // Register-port request codes carried on cmd_pulse.
  typedef enum logic [1:0] {
    COMMAND_NONE = 2'd0,
    COMMAND_XFER = 2'd1,
    COMMAND_LDAC = 2'd2,
    COMMAND_CLR  = 2'd3
  } command_t;

  // LTC2656 command nibbles (upper nibble of the 24-bit frame).
  localparam logic [3:0] WRITE_N        = 4'd0;
  localparam logic [3:0] UPDATE_N       = 4'd1;
  localparam logic [3:0] WRITE_UPDATE_N = 4'd3;
  localparam logic [3:0] POWER_DOWN_N   = 4'd4;

  localparam int FRAME_BITS = 24;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    HOLD  = 3'd2,
    GAP   = 3'd3,
    PULSE = 3'd4
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ltc2656_spi_tx.sv
// Mode-0 SPI serializer for one 24-bit frame: divider, shift register, bit counter.
// start loads the frame and drives bit 23 immediately; done flags the last cycle
// of the bit-0 high phase. SCK returns low and MOSI to 0 after the frame.
module ltc2656_spi_tx
  import ltc2656_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] frame,
  output logic                  sck,
  output logic                  mosi,
  output logic                  done
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

  // Holds the bits still to be sent after the one currently on mosi.
  logic [FRAME_BITS-2:0] shreg;
  logic [4:0]            bit_cnt;
  logic [DIV_W-1:0]      div_cnt;
  logic                  active;

  assign done = active && sck && (div_cnt == '0) && (bit_cnt == '0);

  // Phase timing: each SCK phase lasts CLK_DIV cycles; mosi only moves as sck falls.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      active  <= 1'b0;
      sck     <= 1'b0;
      mosi    <= 1'b0;
    end else if (start) begin
      shreg   <= frame[FRAME_BITS-2:0];
      mosi    <= frame[FRAME_BITS-1];
      sck     <= 1'b0;
      bit_cnt <= 5'(FRAME_BITS - 1);
      div_cnt <= DIV_LOAD;
      active  <= 1'b1;
    end else if (active) begin
      if (div_cnt != '0) begin
        div_cnt <= div_cnt - DIV_W'(1);
      end else begin
        div_cnt <= DIV_LOAD;
        if (!sck) begin
          sck <= 1'b1;
        end else begin
          sck <= 1'b0;
          if (bit_cnt == '0) begin
            active <= 1'b0;
            mosi   <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt - 5'd1;
            mosi    <= shreg[FRAME_BITS-2];
            shreg   <= {shreg[FRAME_BITS-3:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: rtl/ltc2656_sequencer.sv
// LTC2656 DAC sequencer: arbitrates register requests (priority, 1-deep latch)
// and a valid/ready frame stream, runs SPI frames and LDAC_n/CLR_n pulses.
//
// state | meaning
// IDLE  | waiting; consumes the pending request first, else accepts the stream
// SHIFT | frame being clocked out by the serializer, csn low
// HOLD  | CLK_DIV cycles with csn still low after the last SCK high phase
// GAP   | csn high, 2*CLK_DIV cycles before the next operation
// PULSE | ldacn or clrn held low for PULSE_CYCLES cycles
module ltc2656_sequencer
  import ltc2656_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int PULSE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [1:0]  cmd_pulse,
  input  logic [3:0]  reg_cmd,
  input  logic [3:0]  reg_channel,
  input  logic [15:0] reg_value,
  input  logic        strm_valid,
  input  logic [23:0] strm_data,
  output logic        strm_ready,
  output logic        spi_csn,
  output logic        spi_sck,
  output logic        spi_mosi,
  output logic        dac_ldacn,
  output logic        dac_clrn,
  output logic        busy,
  output logic        overrun
);

  localparam int TMR_W = $clog2(max_int(2 * CLK_DIV, PULSE_CYCLES)) + 1;
  localparam logic [TMR_W-1:0] HOLD_LOAD  = TMR_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(2 * CLK_DIV - 1);
  localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_CYCLES - 1);

  state_t                state;
  logic                  pend_valid;
  command_t              pend_op;
  logic [FRAME_BITS-1:0] pend_frame;
  logic [TMR_W-1:0]      timer;

  logic                  idle;
  logic                  consume;
  logic                  pend_is_pulse;
  logic                  tx_start;
  logic                  tx_done;
  logic [FRAME_BITS-1:0] tx_frame;

  assign idle          = (state == IDLE);
  assign consume       = idle && pend_valid;
  assign pend_is_pulse = (pend_op == COMMAND_LDAC) || (pend_op == COMMAND_CLR);
  assign tx_start      = idle && (pend_valid ? !pend_is_pulse : strm_valid);
  assign tx_frame      = pend_valid ? pend_frame : strm_data;
  assign strm_ready    = resetn && idle && !pend_valid;
  assign busy          = !idle || pend_valid;

  ltc2656_spi_tx #(.CLK_DIV(CLK_DIV)) u_spi_tx (
    .clk    (clk),
    .resetn (resetn),
    .start  (tx_start),
    .frame  (tx_frame),
    .sck    (spi_sck),
    .mosi   (spi_mosi),
    .done   (tx_done)
  );

  // One-deep request latch; a request arriving while it is full and not being consumed is dropped.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pend_valid <= 1'b0;
      pend_op    <= COMMAND_NONE;
      pend_frame <= '0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (cmd_pulse != COMMAND_NONE) begin
        if (pend_valid && !consume) begin
          overrun <= 1'b1;
        end else begin
          pend_valid <= 1'b1;
          pend_op    <= command_t'(cmd_pulse);
          pend_frame <= {reg_cmd, reg_channel, reg_value};
        end
      end else if (consume) begin
        pend_valid <= 1'b0;
      end
    end
  end

  // Sequencer FSM with registered csn/ldacn/clrn and a shared down-counting phase timer.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      spi_csn   <= 1'b1;
      dac_ldacn <= 1'b1;
      dac_clrn  <= 1'b1;
      timer     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pend_valid) begin
            case (pend_op)
              COMMAND_LDAC: begin
                state     <= PULSE;
                dac_ldacn <= 1'b0;
                timer     <= PULSE_LOAD;
              end
              COMMAND_CLR: begin
                state    <= PULSE;
                dac_clrn <= 1'b0;
                timer    <= PULSE_LOAD;
              end
              default: begin
                state   <= SHIFT;
                spi_csn <= 1'b0;
              end
            endcase
          end else if (strm_valid) begin
            state   <= SHIFT;
            spi_csn <= 1'b0;
          end
        end
        SHIFT: begin
          if (tx_done) begin
            state <= HOLD;
            timer <= HOLD_LOAD;
          end
        end
        HOLD: begin
          if (timer == '0) begin
            state   <= GAP;
            spi_csn <= 1'b1;
            timer   <= GAP_LOAD;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        PULSE: begin
          if (timer == '0) begin
            state     <= GAP;
            dac_ldacn <= 1'b1;
            dac_clrn  <= 1'b1;
            timer     <= GAP_LOAD;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        GAP: begin
          if (timer == '0) begin
            state <= IDLE;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ltc2656_sequencer.sv
// Bench for ltc2656_sequencer: directed scenarios plus a randomized run, checked
// against an operation-level model (1-deep pending slot, engine busy durations).
module tb_ltc2656_sequencer;

  localparam int D = 2;
  localparam int P = 4;
  // Cycles from the cycle after an operation starts until the engine is idle again.
  localparam int FRAME_DUR = 48 * D + D + 2 * D;
  localparam int PULSE_DUR = P + 2 * D;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  cmd_pulse = 2'd0;
  logic [3:0]  reg_cmd = 4'd0;
  logic [3:0]  reg_channel = 4'd0;
  logic [15:0] reg_value = 16'd0;
  logic        strm_valid = 1'b0;
  logic [23:0] strm_data = 24'd0;
  logic        strm_ready, spi_csn, spi_sck, spi_mosi, dac_ldacn, dac_clrn, busy, overrun;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ltc2656_sequencer #(.CLK_DIV(D), .PULSE_CYCLES(P)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .cmd_pulse   (cmd_pulse),
    .reg_cmd     (reg_cmd),
    .reg_channel (reg_channel),
    .reg_value   (reg_value),
    .strm_valid  (strm_valid),
    .strm_data   (strm_data),
    .strm_ready  (strm_ready),
    .spi_csn     (spi_csn),
    .spi_sck     (spi_sck),
    .spi_mosi    (spi_mosi),
    .dac_ldacn   (dac_ldacn),
    .dac_clrn    (dac_clrn),
    .busy        (busy),
    .overrun     (overrun)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- pin monitor: rebuild frames and pulses from the pins ----------------
  logic        p_csn = 1'b1, p_sck = 1'b0, p_mosi = 1'b0, p_ldacn = 1'b1, p_clrn = 1'b1;
  logic [23:0] m_sh = 24'd0;
  int          m_bits = 0, m_csn_len = 0, hi_len = 0, l_len = 0, c_len = 0;
  bit          m_abort = 1'b0, gap_valid = 1'b0;
  int          ldac_rise_cyc = 0, clr_fall_cyc = 0;
  logic [25:0] obs_q[$];

  always @(negedge clk) begin
    if (!resetn) gap_valid = 1'b0;
    if (!resetn && !spi_csn) m_abort = 1'b1;
    if (!spi_csn) begin
      if (p_csn) begin
        if (gap_valid) check_eq("csn_high_gap", 32'(hi_len >= 2 * D), 32'd1);
        m_bits = 0;
        m_sh = 24'd0;
        m_csn_len = 0;
      end
      m_csn_len++;
      if (!p_sck && spi_sck) begin
        m_sh = {m_sh[22:0], spi_mosi};
        m_bits++;
      end
      if (!p_csn && (spi_mosi !== p_mosi))
        check_eq("mosi_on_sck_fall", 32'({p_sck, spi_sck}), 32'd2);
    end else begin
      if (!p_csn) begin
        if (!m_abort) begin
          check_eq("frame_bits", 32'(m_bits), 32'd24);
          check_eq("csn_low_cycles", 32'(m_csn_len), 32'(49 * D));
          obs_q.push_back({2'd1, m_sh});
          gap_valid = 1'b1;
        end else begin
          gap_valid = 1'b0;
        end
        m_abort = 1'b0;
        hi_len = 0;
      end
      hi_len++;
    end
    if (!dac_ldacn) begin
      l_len++;
      check_eq("ldac_pins_static", 32'({spi_sck, spi_csn}), 32'd1);
    end else if (!p_ldacn) begin
      check_eq("ldacn_low_cycles", 32'(l_len), 32'(P));
      obs_q.push_back({2'd2, 24'd0});
      ldac_rise_cyc = cyc;
      l_len = 0;
    end
    if (!dac_clrn) begin
      if (p_clrn) clr_fall_cyc = cyc;
      c_len++;
      check_eq("clr_pins_static", 32'({spi_sck, spi_csn}), 32'd1);
    end else if (!p_clrn) begin
      check_eq("clrn_low_cycles", 32'(c_len), 32'(P));
      obs_q.push_back({2'd3, 24'd0});
      c_len = 0;
    end
    p_csn = spi_csn;
    p_sck = spi_sck;
    p_mosi = spi_mosi;
    p_ldacn = dac_ldacn;
    p_clrn = dac_clrn;
  end

  // ---------------- reference model: pending slot + engine-free time ----------------
  int          m_cyc = 0, m_free = 0;
  bit          m_pv = 1'b0, m_over = 1'b0;
  logic [1:0]  m_pop = 2'd0;
  logic [23:0] m_pframe = 24'd0;
  logic [25:0] exp_q[$];
  logic [23:0] src_q[$];
  logic        s_csn, s_sck, s_mosi, s_ldacn, s_clrn, s_over, s_ready, s_busy;

  // One clock cycle: present inputs, sample and check at negedge, advance the model.
  task automatic tick();
    bit idle, consume, take, drop;
    logic [25:0] tmp;
    logic [23:0] tmp_src;
    strm_valid = (src_q.size() > 0);
    strm_data = strm_valid ? src_q[0] : 24'd0;
    @(negedge clk);
    s_csn = spi_csn; s_sck = spi_sck; s_mosi = spi_mosi; s_ldacn = dac_ldacn;
    s_clrn = dac_clrn; s_over = overrun; s_ready = strm_ready; s_busy = busy;
    idle = (m_cyc >= m_free);
    check_eq("strm_ready", 32'(strm_ready), 32'(resetn && idle && !m_pv));
    check_eq("busy", 32'(busy), 32'(!idle || m_pv));
    if (resetn) check_eq("overrun", 32'(overrun), 32'(m_over));
    if (!resetn) begin
      if (!idle && exp_q.size() > 0) tmp = exp_q.pop_back();
      m_pv = 1'b0;
      m_over = 1'b0;
      m_free = m_cyc + 1;
    end else begin
      consume = idle && m_pv;
      take = idle && !m_pv && strm_valid;
      drop = 1'b0;
      if (consume) begin
        exp_q.push_back((m_pop == 2'd1) ? {2'd1, m_pframe} : {m_pop, 24'd0});
        m_free = m_cyc + 1 + ((m_pop == 2'd1) ? FRAME_DUR : PULSE_DUR);
      end else if (take) begin
        exp_q.push_back({2'd1, strm_data});
        m_free = m_cyc + 1 + FRAME_DUR;
        tmp_src = src_q.pop_front();
      end
      if (cmd_pulse != 2'd0) begin
        if (m_pv && !consume) begin
          drop = 1'b1;
        end else begin
          m_pv = 1'b1;
          m_pop = cmd_pulse;
          m_pframe = {reg_cmd, reg_channel, reg_value};
        end
      end else if (consume) begin
        m_pv = 1'b0;
      end
      m_over = drop;
    end
    m_cyc++;
    @(posedge clk);
    #1;
    cmd_pulse = 2'd0;
  endtask

  task automatic pulse_reg(input logic [1:0] op, input logic [23:0] f);
    cmd_pulse = op;
    {reg_cmd, reg_channel, reg_value} = f;
    tick();
  endtask

  task automatic drain();
    int n = 0;
    while ((m_cyc < m_free || m_pv || src_q.size() > 0) && n < 5000) begin
      tick();
      n++;
    end
    check_eq("drain_in_time", 32'(n < 5000), 32'd1);
    repeat (4) tick();
  endtask

  task automatic compare_queues(input string tag);
    check_eq("op_count", 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check_eq(tag, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_obs(input int idx, input logic [25:0] exp);
    check_eq("obs_order", 32'((obs_q.size() > idx) ? obs_q[idx] : 26'h0), 32'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int gap;
    logic [1:0] op;
    @(posedge clk);
    #1;
    // Reset state
    resetn = 1'b0;
    repeat (3) tick();
    check_eq("rst_csn", 32'(s_csn), 32'd1);
    check_eq("rst_sck", 32'(s_sck), 32'd0);
    check_eq("rst_mosi", 32'(s_mosi), 32'd0);
    check_eq("rst_ldacn", 32'(s_ldacn), 32'd1);
    check_eq("rst_clrn", 32'(s_clrn), 32'd1);
    check_eq("rst_overrun", 32'(s_over), 32'd0);
    resetn = 1'b1;
    tick();

    // Register XFER latency and content
    pulse_reg(2'd1, 24'h351234);
    tick();
    check_eq("lat_csn_t1", 32'(s_csn), 32'd1);
    tick();
    check_eq("lat_csn_t2", 32'(s_csn), 32'd0);
    check_eq("lat_mosi_b23", 32'(s_mosi), 32'd0);
    drain();
    check_obs(0, {2'd1, 24'h351234});
    compare_queues("xfer_frame");

    // LDAC and CLR pulses on their own
    pulse_reg(2'd2, 24'h0);
    drain();
    pulse_reg(2'd3, 24'h0);
    drain();
    check_obs(0, {2'd2, 24'd0});
    check_obs(1, {2'd3, 24'd0});
    compare_queues("pulse_ops");

    // Stream pair with a register XFER landing mid-first-frame
    src_q.push_back(24'h3FABCD);
    src_q.push_back(24'h300010);
    repeat (20) tick();
    pulse_reg(2'd1, 24'h31FFFF);
    drain();
    check_obs(0, {2'd1, 24'h3FABCD});
    check_obs(1, {2'd1, 24'h31FFFF});
    check_obs(2, {2'd1, 24'h300010});
    compare_queues("arb_order");

    // Two register XFERs during an active frame: second one dropped
    src_q.push_back(24'h300001);
    repeat (10) tick();
    pulse_reg(2'd1, 24'h3AAAAA);
    repeat (9) tick();
    pulse_reg(2'd1, 24'h3BBBBB);
    tick();
    check_eq("overrun_pulse", 32'(s_over), 32'd1);
    tick();
    check_eq("overrun_one_cycle", 32'(s_over), 32'd0);
    drain();
    check_obs(0, {2'd1, 24'h300001});
    check_obs(1, {2'd1, 24'h3AAAAA});
    compare_queues("overrun_ops");

    // Reset in the middle of a frame with a request pending
    pulse_reg(2'd1, 24'h3C0FFE);
    repeat (5) tick();
    pulse_reg(2'd1, 24'h355555);
    n = 0;
    while (m_bits < 10 && n < 500) begin
      tick();
      n++;
    end
    check_eq("bit10_reached", 32'(m_bits >= 10), 32'd1);
    resetn = 1'b0;
    tick();
    tick();
    check_eq("abort_csn", 32'(s_csn), 32'd1);
    check_eq("abort_sck", 32'(s_sck), 32'd0);
    check_eq("abort_pend_clear", 32'(s_busy), 32'd0);
    check_eq("ready_in_reset", 32'(s_ready), 32'd0);
    resetn = 1'b1;
    tick();
    check_eq("ready_after_rst", 32'(s_ready), 32'd1);
    pulse_reg(2'd1, 24'h3DEAD1);
    drain();
    check_obs(0, {2'd1, 24'h3DEAD1});
    compare_queues("post_reset");

    // LDAC then CLR on consecutive cycles
    pulse_reg(2'd2, 24'h0);
    pulse_reg(2'd3, 24'h0);
    drain();
    gap = clr_fall_cyc - ldac_rise_cyc;
    check_eq("ldac_clr_gap", 32'(gap >= 2 * D && gap <= 2 * D + 1), 32'd1);
    compare_queues("ldac_clr");

    // Randomized mix of register requests and stream frames
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 4) begin
        n = $urandom_range(0, 9);
        op = (n < 6) ? 2'd1 : ((n < 8) ? 2'd2 : 2'd3);
        cmd_pulse = op;
        {reg_cmd, reg_channel, reg_value} = 24'($urandom);
      end
      if ($urandom_range(0, 99) < 3 && src_q.size() < 3)
        src_q.push_back(24'($urandom));
      tick();
    end
    drain();
    compare_queues("random_ops");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
